// File: rtl/pipe_skid_register.sv
// Two-entry elastic pipeline register (skid buffer) with a registered in_ready.
// Optional flush port is enabled by defining PIPE_SKID_FLUSH_EN.
module pipe_skid_register #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic [15:0]           stall_count,
  output logic [1:0]            dbg_state
);

  // Handshake: a word moves on an edge where valid and ready are both 1.
  // in_ready depends only on the state register (and reset), never on out_ready.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [15:0]           r_stall;

  logic w_in_fire;
  logic w_out_fire;

  assign in_ready    = (r_state != ST_FULL) & ~reset;
  assign out_valid   = (r_state != ST_EMPTY);
  assign output_data = r_main;
  assign stall_count = r_stall;
  assign dbg_state   = r_state;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_main  <= RESET_VALUE;
      r_skid  <= RESET_VALUE;
      r_stall <= '0;
    end else begin
      // Saturating stall counter; flush does not clear it.
      if (out_valid && !out_ready && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 16'd1;
      end
`ifdef PIPE_SKID_FLUSH_EN
      if (flush) begin
        r_state <= ST_EMPTY;
      end else
`endif
      begin
        case (r_state)
          ST_EMPTY: begin
            if (w_in_fire) begin
              r_main  <= input_data;
              r_state <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            if (w_in_fire && w_out_fire) begin
              r_main <= input_data;
            end else if (w_in_fire) begin
              r_skid  <= input_data;
              r_state <= ST_FULL;
            end else if (w_out_fire) begin
              r_state <= ST_EMPTY;
            end
          end
          ST_FULL: begin
            // in_ready is 0 here, so only the drain side can move.
            if (w_out_fire) begin
              r_main  <= r_skid;
              r_state <= ST_BUSY;
            end
          end
          default: r_state <= ST_EMPTY;
        endcase
      end
    end
  end

endmodule
